// File: rtl/ram_mov_moc_pkg.sv
// Shared definitions for the ram_mov_moc byte-addressable RAM:
// access-size encodings, read/write encodings, FSM state type and
// a helper that flags misaligned or reserved-size requests.
package ram_mov_moc_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // True when the request must be rejected without touching memory.
  function automatic logic req_error(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_mov_moc_if.sv
// Request/response bus of ram_mov_moc.
//   master: drives MOV, RW, size, sgn, addr, DataIn; observes DataOut, MOC, err
//   slave : the RAM side (mirror image)
interface ram_mov_moc_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              MOV;
  logic              RW;
  logic [1:0]        size;
  logic              sgn;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MOC;
  logic              err;

  modport master (
    output MOV, RW, size, sgn, addr, DataIn,
    input  DataOut, MOC, err
  );

  modport slave (
    input  MOV, RW, size, sgn, addr, DataIn,
    output DataOut, MOC, err
  );
endinterface

// File: rtl/ram_lane_align.sv
// Combinational byte-lane steering for ram_mov_moc.
//   size_i/sgn_i/off_i : access size, sign-extend flag, address offset within word
//   rbytes_i           : the four bytes of the addressed word, index = address offset
//   wdata_i            : store data, right-justified
//   rdata_o            : load result, right-justified and extended
//   be_o / wbytes_o    : per-offset byte enables and byte values for stores
module ram_lane_align
  import ram_mov_moc_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]      size_i,
  input  logic            sgn_i,
  input  logic [1:0]      off_i,
  input  logic [3:0][7:0] rbytes_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  output logic [3:0]      be_o,
  output logic [3:0][7:0] wbytes_o
);

  logic [1:0]  off_lo;
  logic [1:0]  off_hi;
  logic [15:0] half_w;

  // Halfwords only reach here aligned, so the pair is always {even, odd}.
  assign off_lo = {off_i[1], 1'b0};
  assign off_hi = {off_i[1], 1'b1};

  always_comb begin
    rdata_o  = '0;
    be_o     = '0;
    wbytes_o = '0;
    half_w   = '0;
    case (size_i)
      SZ_BYTE: begin
        rdata_o          = {{24{sgn_i & rbytes_i[off_i][7]}}, rbytes_i[off_i]};
        be_o[off_i]      = 1'b1;
        wbytes_o[off_i]  = wdata_i[7:0];
      end
      SZ_HALF: begin
        if (BIG_ENDIAN) begin
          half_w           = {rbytes_i[off_lo], rbytes_i[off_hi]};
          wbytes_o[off_lo] = wdata_i[15:8];
          wbytes_o[off_hi] = wdata_i[7:0];
        end else begin
          half_w           = {rbytes_i[off_hi], rbytes_i[off_lo]};
          wbytes_o[off_lo] = wdata_i[7:0];
          wbytes_o[off_hi] = wdata_i[15:8];
        end
        rdata_o      = {{16{sgn_i & half_w[15]}}, half_w};
        be_o[off_lo] = 1'b1;
        be_o[off_hi] = 1'b1;
      end
      SZ_WORD: begin
        be_o = 4'b1111;
        for (int k = 0; k < 4; k++) begin
          if (BIG_ENDIAN) begin
            rdata_o[8*(3-k) +: 8] = rbytes_i[k];
            wbytes_o[k]           = wdata_i[8*(3-k) +: 8];
          end else begin
            rdata_o[8*k +: 8] = rbytes_i[k];
            wbytes_o[k]       = wdata_i[8*k +: 8];
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_mov_moc.sv
// Byte-addressable RAM with a MOV/MOC request-complete handshake and a
// fixed access latency.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : slave side of ram_mov_moc_if (MOV, RW, size, sgn, addr,
//                DataIn in; DataOut, MOC, err out)
// Memory array is named Mem and is not cleared by reset.
module ram_mov_moc
  import ram_mov_moc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned LATENCY    = 2,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input logic         clk,
  input logic         reset,
  ram_mov_moc_if.slave bus
);

  localparam int unsigned Depth   = 1 << ADDR_W;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  logic [7:0] Mem [Depth];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       dout_q, dout_d;
  logic              err_q, err_d;
  logic              commit;

  logic [ADDR_W-3:0] word_idx;
  logic [3:0][7:0]   rbytes;
  logic [3:0][7:0]   wbytes;
  logic [3:0]        be;
  logic [31:0]       rdata;

  assign word_idx = addr_q[ADDR_W-1:2];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rbytes[k] = Mem[{word_idx, 2'(k)}];
    end
  end

  ram_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .size_i  (size_q),
    .sgn_i   (sgn_q),
    .off_i   (addr_q[1:0]),
    .rbytes_i(rbytes),
    .wdata_i (din_q),
    .rdata_o (rdata),
    .be_o    (be),
    .wbytes_o(wbytes)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.MOV) begin
          rw_d   = bus.RW;
          size_d = bus.size;
          sgn_d  = bus.sgn;
          addr_d = bus.addr;
          din_d  = bus.DataIn;
          if (req_error(bus.size, bus.addr[1:0])) begin
            state_d = StDone;
            err_d   = 1'b1;
            dout_d  = '0;
          end else begin
            state_d = StBusy;
            cnt_d   = CntInit;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          commit  = 1'b1;
          if (rw_q == RW_READ) dout_d = rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (!bus.MOV) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rw_q    <= RW_READ;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Reset in the commit cycle aborts the store.
  always_ff @(posedge clk) begin
    if (!reset && commit && (rw_q == RW_WRITE)) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) Mem[{word_idx, 2'(k)}] <= wbytes[k];
      end
    end
  end

  assign bus.MOC     = (state_q == StDone);
  assign bus.err     = err_q;
  assign bus.DataOut = dout_q;

endmodule

// File: tb/tb_ram_mov_moc.sv
// Self-checking bench for ram_mov_moc: a big-endian LATENCY=2 instance and
// a little-endian LATENCY=1 instance share clock and reset. Expected results
// are queued when a request is driven and compared when MOC rises.
module tb_ram_mov_moc;
  import ram_mov_moc_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    logic        rw;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ram_mov_moc_if #(.ADDR_W(9)) bus0 ();
  ram_mov_moc_if #(.ADDR_W(9)) bus1 ();

  ram_mov_moc #(
    .ADDR_W    (9),
    .LATENCY   (2),
    .BIG_ENDIAN(1'b1)
  ) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  ram_mov_moc #(
    .ADDR_W    (9),
    .LATENCY   (1),
    .BIG_ENDIAN(1'b0)
  ) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic mov, input logic rw, input logic [1:0] sz,
                       input logic sg, input logic [8:0] ad, input logic [31:0] di);
    if (sel == 0) begin
      bus0.MOV = mov; bus0.RW = rw; bus0.size = sz; bus0.sgn = sg;
      bus0.addr = ad; bus0.DataIn = di;
    end else begin
      bus1.MOV = mov; bus1.RW = rw; bus1.size = sz; bus1.sgn = sg;
      bus1.addr = ad; bus1.DataIn = di;
    end
  endtask

  task automatic sample(input int sel, output logic moc, output logic er,
                        output logic [31:0] dout);
    if (sel == 0) begin
      moc = bus0.MOC; er = bus0.err; dout = bus0.DataOut;
    end else begin
      moc = bus1.MOC; er = bus1.err; dout = bus1.DataOut;
    end
  endtask

  // exp_bytes holds the byte at base in its top byte, base+3 in its bottom byte.
  task automatic check_mem(input int sel, input logic [8:0] base, input logic [31:0] exp_bytes,
                           input string tag);
    logic [7:0] got;
    for (int k = 0; k < 4; k++) begin
      if (sel == 0) got = dut0.Mem[9'(base + k)];
      else          got = dut1.Mem[9'(base + k)];
      check_eq($sformatf("%s[%0d]", tag, k), {24'h0, got}, {24'h0, exp_bytes[8*(3-k) +: 8]});
    end
  endtask

  // One full handshake; inputs are scrambled after acceptance and must be ignored.
  task automatic op(input int sel, input logic rw, input logic [1:0] sz, input logic sg,
                    input logic [8:0] ad, input logic [31:0] di, input logic [31:0] exp_data,
                    input logic exp_err, input int exp_lat, input int hold, input string tag);
    exp_t        e;
    int          cyc;
    logic        moc;
    logic        er;
    logic [31:0] dout;
    exp_q.push_back('{data: exp_data, err: exp_err, lat: exp_lat, rw: rw});
    @(negedge clk);
    drive(sel, 1'b1, rw, sz, sg, ad, di);
    @(posedge clk);
    #1;
    drive(sel, 1'b1, ~rw, ~sz, ~sg, ~ad, ~di);
    cyc = 0;
    moc = 1'b0;
    while (!moc && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      sample(sel, moc, er, dout);
    end
    e = exp_q.pop_front();
    check_eq({tag, "/lat"}, 32'(cyc), 32'(e.lat));
    if (moc) begin
      check_eq({tag, "/err"}, {31'h0, er}, {31'h0, e.err});
      if (e.rw == RW_READ || e.err) check_eq({tag, "/data"}, dout, e.data);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        sample(sel, moc, er, dout);
        check_eq({tag, "/hold"}, {31'h0, moc}, 32'h1);
      end
    end
    @(negedge clk);
    drive(sel, 1'b0, rw, sz, sg, ad, di);
    @(posedge clk);
    #1;
    sample(sel, moc, er, dout);
    check_eq({tag, "/release"}, {30'h0, moc, er}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        moc;
    logic        er;
    logic [31:0] dout;
    drive(0, 1'b0, RW_READ, SZ_BYTE, 1'b0, 9'h0, 32'h0);
    drive(1, 1'b0, RW_READ, SZ_BYTE, 1'b0, 9'h0, 32'h0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s, moc, er, dout);
      check_eq($sformatf("reset%0d/moc", s), {31'h0, moc}, 32'h0);
      check_eq($sformatf("reset%0d/err", s), {31'h0, er}, 32'h0);
      check_eq($sformatf("reset%0d/dout", s), dout, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Big-endian, LATENCY=2
    op(0, RW_WRITE, SZ_WORD, 1'b0, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, "st_w10");
    check_mem(0, 9'h010, 32'hDEADBEEF, "mem10");
    op(0, RW_READ, SZ_BYTE, 1'b1, 9'h011, 32'h0, 32'hFFFFFFAD, 1'b0, 2, 0, "ld_bs11");
    op(0, RW_READ, SZ_BYTE, 1'b0, 9'h011, 32'h0, 32'h000000AD, 1'b0, 2, 0, "ld_bu11");
    op(0, RW_READ, SZ_HALF, 1'b1, 9'h010, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 0, "ld_hs10");
    op(0, RW_WRITE, SZ_HALF, 1'b0, 9'h012, 32'hAAAA1234, 32'h0, 1'b0, 2, 0, "st_h12");
    op(0, RW_READ, SZ_WORD, 1'b0, 9'h010, 32'h0, 32'hDEAD1234, 1'b0, 2, 0, "ld_w10");
    op(0, RW_READ, SZ_BYTE, 1'b1, 9'h013, 32'h0, 32'h00000034, 1'b0, 2, 0, "ld_bs13");

    // Rejected requests: one cycle, err, DataOut cleared, no memory effect
    op(0, RW_READ, SZ_WORD, 1'b0, 9'h013, 32'h0, 32'h0, 1'b1, 1, 0, "ld_w13_mis");
    op(0, RW_READ, 2'b11, 1'b0, 9'h010, 32'h0, 32'h0, 1'b1, 1, 0, "ld_rsvd");
    op(0, RW_WRITE, SZ_HALF, 1'b0, 9'h011, 32'h00005555, 32'h0, 1'b1, 1, 0, "st_h11_mis");
    op(0, RW_WRITE, SZ_WORD, 1'b0, 9'h012, 32'h66666666, 32'h0, 1'b1, 1, 0, "st_w12_mis");
    check_mem(0, 9'h010, 32'hDEAD1234, "mem10_err");

    // Reset during BUSY aborts the pending store
    op(0, RW_WRITE, SZ_WORD, 1'b0, 9'h020, 32'hCAFEBABE, 32'h0, 1'b0, 2, 0, "st_w20");
    @(negedge clk);
    drive(0, 1'b1, RW_WRITE, SZ_WORD, 1'b0, 9'h020, 32'h0BADF00D);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b0, RW_WRITE, SZ_WORD, 1'b0, 9'h020, 32'h0BADF00D);
    @(posedge clk);
    #1;
    sample(0, moc, er, dout);
    check_eq("abort/moc_rst", {31'h0, moc}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      sample(0, moc, er, dout);
      check_eq("abort/moc_idle", {31'h0, moc}, 32'h0);
    end
    check_eq("abort/dout", dout, 32'h0);
    check_mem(0, 9'h020, 32'hCAFEBABE, "mem20");
    op(0, RW_READ, SZ_WORD, 1'b0, 9'h020, 32'h0, 32'hCAFEBABE, 1'b0, 2, 0, "ld_w20");

    // Little-endian, LATENCY=1, top of memory, MOV held
    op(1, RW_WRITE, SZ_WORD, 1'b0, 9'h1FC, 32'h11223344, 32'h0, 1'b0, 1, 5, "le_st_w1fc");
    check_mem(1, 9'h1FC, 32'h44332211, "mem1fc");
    op(1, RW_READ, SZ_WORD, 1'b0, 9'h1FC, 32'h0, 32'h11223344, 1'b0, 1, 0, "le_ld_w1fc");
    op(1, RW_READ, SZ_HALF, 1'b0, 9'h1FE, 32'h0, 32'h00001122, 1'b0, 1, 0, "le_ld_h1fe");
    op(1, RW_READ, SZ_BYTE, 1'b1, 9'h1FD, 32'h0, 32'h00000033, 1'b0, 1, 0, "le_ld_b1fd");
    op(1, RW_WRITE, SZ_HALF, 1'b0, 9'h1FC, 32'h0000ABCD, 32'h0, 1'b0, 1, 0, "le_st_h1fc");
    op(1, RW_READ, SZ_WORD, 1'b0, 9'h1FC, 32'h0, 32'h1122ABCD, 1'b0, 1, 0, "le_ld_w1fc2");
    op(1, RW_READ, SZ_HALF, 1'b1, 9'h1FC, 32'h0, 32'hFFFFABCD, 1'b0, 1, 0, "le_ld_hs1fc");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_mov_moc.md
RAM_MOV_MOC -- requirements
Module: ram_mov_moc

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, byte-address width; depth = 2**ADDR_W bytes.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from accepted request to MOC; legal range 1..15.
REQ-003 SHALL have parameter BIG_ENDIAN, default 1; 1 = byte at lowest address is MSB of the word.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port MOV  input  1  memory operation valid; request held high until MOC seen.
REQ-007 SHALL have port RW  input  1  1 = read (load), 0 = write (store).
REQ-008 SHALL have port size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SHALL have port sgn  input  1  sign-extend byte/halfword loads when 1, zero-extend when 0.
REQ-010 SHALL have port addr  input  ADDR_W  byte address.
REQ-011 SHALL have port DataIn  input  32  store data; byte/halfword taken from low bits.
REQ-012 SHALL have port DataOut  output  32  load result, right-justified and extended.
REQ-013 SHALL have port MOC  output  1  memory operation complete.
REQ-014 SHALL have port err  output  1  misaligned or reserved-size request; valid while MOC=1.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 IDLE: on edge with MOV=1, SHALL latch RW, size, sgn, addr, DataIn and enter BUSY with counter = LATENCY-1.
REQ-017 Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11: SHALL enter DONE directly from IDLE with err=1, no memory access, DataOut=0.
REQ-018 BUSY: counter SHALL decrement each cycle; at 0, next edge SHALL enter DONE and commit the access.
REQ-019 Thus MOC SHALL rise exactly LATENCY cycles after the edge accepting MOV (1 cycle for errors).
REQ-020 Stores SHALL write only addressed bytes at the BUSY->DONE edge; other bytes unchanged.
REQ-021 Loads SHALL register DataOut at the BUSY->DONE edge; DataOut SHALL hold until the next load completes or reset.
REQ-022 DONE: MOC=1 while MOV=1; on edge with MOV=0, SHALL return to IDLE with MOC=0, err=0.
REQ-023 Inputs changing while BUSY/DONE SHALL be ignored; new request requires MOV low for one edge first.
REQ-024 Byte lane order SHALL follow BIG_ENDIAN for halfword and word accesses.
REQ-025 Address arithmetic SHALL be within ADDR_W bits; aligned accesses never cross end of memory.

Reset
REQ-026 On edge with reset=1: state IDLE, MOC=0, err=0, DataOut=0, counter=0.
REQ-027 Reset while BUSY SHALL abort the access; pending store SHALL NOT be committed.
REQ-028 Memory contents SHALL NOT be cleared by reset; array SHALL be hierarchically accessible as Mem for bench preload/dump.

Structure
REQ-029 Shared package SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state encoding, and RW read/write constants.
REQ-030 One sub-module SHALL exist: ram_lane_align, combinational byte-lane steering/extension for loads and byte-enable generation for stores.

Verification
REQ-031 Reset, LATENCY=2; word store 0xDEADBEEF @0x010, MOV held -> MOC high 2 cycles after accept, err=0; Mem[0x10..0x13]=DE,AD,BE,EF.
REQ-032 Byte load sgn=1 @0x011 after REQ-031 -> DataOut=0xFFFFFFAD; sgn=0 -> 0x000000AD.
REQ-033 Halfword store 0x1234 @0x012 then word load @0x010 -> DataOut=0xDEAD1234.
REQ-034 Word load @0x013 -> MOC 1 cycle after accept, err=1, DataOut=0, memory unchanged; size=11 same.
REQ-035 Word store 0x0BADF00D @0x020, reset asserted in BUSY -> MOC stays 0, Mem[0x20..0x23] unchanged, next load returns prior contents.
REQ-036 LATENCY=1 and BIG_ENDIAN=0 build: word store 0x11223344 @0x1FC -> Mem[0x1FC]=44, Mem[0x1FF]=11; MOC 1 cycle after accept; MOV held 5 cycles -> MOC stays 1 until MOV low.
